// File: rtl/cam_req_arbiter_if.sv
// cam_req_arbiter_if: requester-side bus of the two-client CAM arbiter
interface cam_req_arbiter_if #(
  parameter int key_width_p = 16,
  parameter int val_width_p = 16
);
  logic [1:0]               req;
  logic [1:0]               rw_n;
  logic [2*key_width_p-1:0] key;
  logic [2*val_width_p-1:0] val;
  logic [1:0]               gnt;
  logic [1:0]               resp_valid;
  logic [1:0]               resp_ready;
  logic [1:0]               resp_hit;
  logic [2*val_width_p-1:0] resp_val;
  modport master (
    output req, rw_n, key, val, resp_ready,
    input  gnt, resp_valid, resp_hit, resp_val
  );
  modport slave (
    input  req, rw_n, key, val, resp_ready,
    output gnt, resp_valid, resp_hit, resp_val
  );
endinterface

// File: rtl/cam_req_arbiter.sv
// cam_req_arbiter: round-robin sharing of one CAM port between two requesters
module cam_req_arbiter #(
  parameter int key_width_p = 16,
  parameter int val_width_p = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  cam_req_arbiter_if.slave       bus,
  output logic                   cam_valid_o,
  output logic                   cam_rw_n_o,
  output logic [key_width_p-1:0] cam_key_o,
  output logic [val_width_p-1:0] cam_val_o,
  input  logic                   cam_hit_i,
  input  logic [val_width_p-1:0] cam_val_i
);
  localparam int kw = key_width_p;
  localparam int vw = val_width_p;
  logic [1:0] pend_q, pend_d, rv_q, rv_d, hit_q, hit_d;
  logic [1:0] elig, gnt, cap, drn;
  logic [2*vw-1:0] val_q, val_d;
  logic prio_q, prio_d, iss_v_q, iss_owner_q, iss_rd_q, g, rd_hit;
  // reset masks eligibility so nothing reaches the CAM while rst is high
  assign elig = bus.req & ~pend_q & {2{~rst}};
  assign gnt = &elig ? (prio_q ? 2'b10 : 2'b01) : elig;
  assign g = gnt[1];
  assign bus.gnt = gnt;
  assign cam_valid_o = |gnt;
  assign cam_rw_n_o = cam_valid_o & bus.rw_n[g];
  assign cam_key_o = !cam_valid_o ? '0 : g ? bus.key[2*kw-1:kw] : bus.key[kw-1:0];
  assign cam_val_o = !cam_valid_o ? '0 : g ? bus.val[2*vw-1:vw] : bus.val[vw-1:0];
  assign cap = iss_v_q ? (iss_owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign drn = rv_q & bus.resp_ready;
  assign rd_hit = iss_rd_q & cam_hit_i;
  assign pend_d = (pend_q | gnt) & ~drn;
  assign prio_d = cam_valid_o ? ~g : prio_q;
  always_comb begin
    rv_d = (rv_q & ~drn) | cap;
    hit_d = (hit_q & ~drn & ~cap) | (cap & {2{rd_hit}});
    val_d = val_q;
    for (int r = 0; r < 2; r++)
      val_d[r*vw +: vw] = cap[r] ? (rd_hit ? cam_val_i : '0) : drn[r] ? '0 : val_q[r*vw +: vw];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_q      <= '0;
      prio_q      <= 1'b0;
      iss_v_q     <= 1'b0;
      iss_owner_q <= 1'b0;
      iss_rd_q    <= 1'b0;
      rv_q        <= '0;
      hit_q       <= '0;
      val_q       <= '0;
    end else begin
      pend_q      <= pend_d;
      prio_q      <= prio_d;
      iss_v_q     <= cam_valid_o;
      iss_owner_q <= g;
      iss_rd_q    <= cam_rw_n_o;
      rv_q        <= rv_d;
      hit_q       <= hit_d;
      val_q       <= val_d;
    end
  assign bus.resp_valid = rv_q;
  assign bus.resp_hit = hit_q;
  assign bus.resp_val = val_q;
endmodule

// File: tb/tb_cam_req_arbiter.sv
// tb_cam_req_arbiter: directed checks of arbitration, latency, backpressure and reset
module tb_cam_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cam_req_arbiter_if #(.key_width_p(16), .val_width_p(16)) b ();
  logic        cam_valid, cam_rw_n, cam_hit = 1'b0;
  logic [15:0] cam_key, cam_wval, cam_rval = 16'h0;
  logic [15:0] mem [65536];
  bit          vld [65536];
  int total = 0;
  int bad = 0;
  int c0, c1;
  logic [1:0] e4 [9] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01};
  logic [1:0] e5;
  cam_req_arbiter #(.key_width_p(16), .val_width_p(16)) dut (
    .clk(clk), .rst(rst), .bus(b),
    .cam_valid_o(cam_valid), .cam_rw_n_o(cam_rw_n), .cam_key_o(cam_key), .cam_val_o(cam_wval),
    .cam_hit_i(cam_hit), .cam_val_i(cam_rval)
  );
  // CAM model: one-cycle read latency; writes and misses return junk the DUT must mask
  always @(posedge clk)
    if (cam_valid && !cam_rw_n) begin
      mem[cam_key] <= cam_wval;
      vld[cam_key] <= 1'b1;
      cam_hit      <= 1'b1;
      cam_rval     <= 16'hDEAD;
    end else if (cam_valid && vld[cam_key]) begin
      cam_hit  <= 1'b1;
      cam_rval <= mem[cam_key];
    end else begin
      cam_hit  <= 1'b0;
      cam_rval <= 16'hDEAD;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  initial begin
    b.req = 2'b11; b.rw_n = 2'b11; b.key = '0; b.val = '0; b.resp_ready = 2'b11;
    #12;
    chk("rst_gnt", b.gnt, 2'b00);
    chk("rst_cam_valid", cam_valid, 0);
    chk("rst_resp_valid", b.resp_valid, 2'b00);
    nxt(); rst = 1'b0; #1;
    chk("first_gnt", b.gnt, 2'b01);
    nxt(); #1;
    chk("second_gnt", b.gnt, 2'b10);
    nxt(); b.req = 2'b00;
    repeat (4) nxt();
    // write by req0 then read of same key by req1 on the next cycle
    nxt(); b.req = 2'b01; b.rw_n = 2'b00; b.key = {16'h0000, 16'h0012}; b.val = {16'h0000, 16'hBEEF}; #1;
    chk("wr_gnt", b.gnt, 2'b01);
    chk("wr_rw_n", cam_rw_n, 0);
    chk("wr_key", cam_key, 16'h0012);
    chk("wr_val", cam_wval, 16'hBEEF);
    nxt(); b.req = 2'b10; b.rw_n = 2'b10; b.key = {16'h0012, 16'h0012}; #1;
    chk("rd_gnt", b.gnt, 2'b10);
    chk("rd_rw_n", cam_rw_n, 1);
    chk("rd_key", cam_key, 16'h0012);
    chk("lat_t1_valid", b.resp_valid, 2'b00);
    nxt(); b.req = 2'b00; #1;
    chk("wr_resp_valid", b.resp_valid, 2'b01);
    chk("wr_resp_hit", b.resp_hit[0], 0);
    nxt(); #1;
    chk("rd_resp_valid", b.resp_valid, 2'b10);
    chk("rd_resp_hit", b.resp_hit[1], 1);
    chk("rd_resp_val", b.resp_val[31:16], 16'hBEEF);
    repeat (2) nxt();
    // read miss
    nxt(); b.req = 2'b10; b.rw_n = 2'b11; b.key = {16'h7777, 16'h0000}; #1;
    chk("miss_gnt", b.gnt, 2'b10);
    nxt(); b.req = 2'b00; #1;
    chk("miss_early", b.resp_valid, 2'b00);
    nxt(); #1;
    chk("miss_valid", b.resp_valid[1], 1);
    chk("miss_hit", b.resp_hit[1], 0);
    chk("miss_val", b.resp_val[31:16], 16'h0000);
    repeat (2) nxt();
    // requester 0 stalls its response; requester 1 keeps the CAM busy
    nxt(); b.req = 2'b11; b.key = {16'h0012, 16'h0012}; b.resp_ready = 2'b10; #1;
    chk("bp_gnt0", b.gnt, e4[0]);
    for (int i = 1; i < 9; i++) begin
      nxt();
      if (i == 7) b.resp_ready = 2'b11;
      #1;
      chk($sformatf("bp_gnt%0d", i), b.gnt, e4[i]);
      if (i >= 2 && i <= 7) begin
        chk($sformatf("bp_hold_v%0d", i), b.resp_valid[0], 1);
        chk($sformatf("bp_hold_d%0d", i), b.resp_val[15:0], 16'hBEEF);
      end
    end
    nxt(); b.req = 2'b00;
    repeat (4) nxt();
    // continuous contention: prio currently favours requester 1
    c0 = 0; c1 = 0;
    for (int i = 0; i < 20; i++) begin
      nxt();
      if (i == 0) b.req = 2'b11;
      #1;
      e5 = (i % 3 == 0) ? 2'b10 : (i % 3 == 1) ? 2'b01 : 2'b00;
      chk($sformatf("rr_gnt%0d", i), b.gnt, e5);
      c0 += int'(b.gnt[0]);
      c1 += int'(b.gnt[1]);
    end
    chk("rr_cnt0", c0, 7);
    chk("rr_cnt1", c1, 7);
    nxt(); b.req = 2'b00;
    repeat (4) nxt();
    // reset lands the cycle after a read grant
    nxt(); b.req = 2'b01; b.rw_n = 2'b11; #1;
    chk("rr_pre_gnt", b.gnt, 2'b01);
    nxt(); rst = 1'b1; b.req = 2'b11; #1;
    chk("rst2_gnt", b.gnt, 2'b00);
    chk("rst2_cam_valid", cam_valid, 0);
    chk("rst2_resp_valid", b.resp_valid, 2'b00);
    nxt(); #1;
    chk("rst2_discard", b.resp_valid, 2'b00);
    nxt(); rst = 1'b0; #1;
    chk("post_rst_valid", b.resp_valid, 2'b00);
    chk("post_rst_gnt", b.gnt, 2'b01);
    nxt(); #1;
    chk("post_rst_gnt2", b.gnt, 2'b10);
    chk("post_rst_valid2", b.resp_valid, 2'b00);
    nxt(); b.req = 2'b00; #1;
    chk("post_rst_resp", b.resp_valid, 2'b01);
    repeat (3) nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cam_req_arbiter.md
Name: cam_req_arbiter

Overview:
Shares a single CAM port between two requesters (index 0 and 1) with round-robin arbitration. It issues at most one CAM access per cycle and tags each access with its owner. The CAM result is captured into a per-requester response slot, and the block holds that response until the requester accepts it. It sits between the client logic and the CAM instance, and it is the only driver of the CAM's request inputs.

Parameters:
- key_width_p, 16, CAM key width in bits
- val_width_p, 16, CAM value width in bits

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_i  in  2  per-requester request valid
- rw_n_i  in  2  per-requester 1=read, 0=write
- key_i  in  2*key_width_p  requester r key at bits [r*key_width_p +: key_width_p]
- val_i  in  2*val_width_p  requester r write data, same packing
- gnt_o  out  2  one-hot grant; request accepted this cycle
- resp_valid_o  out  2  response slot r holds a result
- resp_ready_i  in  2  requester r accepts its response
- resp_hit_o  out  2  read hit flag; 0 for writes
- resp_val_o  out  2*val_width_p  read data; 0 on miss or write
- cam_valid_o  out  1  CAM access this cycle
- cam_rw_n_o  out  1  CAM read/write select
- cam_key_o  out  key_width_p  CAM key
- cam_val_o  out  val_width_p  CAM write data
- cam_hit_i  in  1  CAM read hit, valid the cycle after issue
- cam_val_i  in  val_width_p  CAM read data, valid the cycle after issue

Behaviour:
- Per-requester state pend[r] is 1 from the grant until the response handshake.
  - Eligible(r) = req_i[r] && !pend[r].
- Arbitration is combinational in the cycle of the request. A single priority bit prio is reset to 0.
  - Only one requester eligible: grant it.
  - Both eligible: grant prio.
  - After any grant g, prio <= ~g.
  - No grant: prio holds.
- gnt_o is one-hot or zero, and never asserts for an ineligible requester.
- cam_valid_o = |gnt_o.
- cam_rw_n_o, cam_key_o and cam_val_o are muxed from the granted requester. They are 0 when there is no grant.
- Issue stage registers: iss_v <= |gnt_o, iss_owner, iss_rd.
- Capture happens at the edge ending the cycle after issue, when iss_v=1. The owner's slot loads:
  - hit = iss_rd & cam_hit_i
  - val = (iss_rd & cam_hit_i) ? cam_val_i : 0
  - resp_valid_o[owner] <= 1
- Latency: grant in cycle t, resp_valid_o from cycle t+2.
- Slot r clears on resp_valid_o[r] && resp_ready_i[r], which also clears pend[r]. Its next grant is possible in the following cycle.
  - Minimum per-requester initiation interval is 3 cycles.
  - Interleaved requesters may use the CAM on consecutive cycles.
- Capture and drain never coincide on the same slot: capture needs pend=1 with no response yet, and drain needs a response present.
- Requester handshake:
  - req_i/rw_n_i/key_i/val_i must stay stable until gnt_o[r].
  - Inputs are sampled only in the grant cycle.
  - A request deasserted before grant is dropped without side effects.
- Back-to-back write then read to the same key from different requesters is issued in grant order with no hazard logic. The CAM resolves ordering, so the read returns the new value.
- Reset (async, any time) forces:
  - pend=0, prio=0, iss_v=0
  - all resp_valid_o=0, resp_hit_o=0, resp_val_o=0
  - any in-flight access result is discarded
  - cam_valid_o=0 while rst=1
- resp_valid_o, resp_hit_o and resp_val_o come directly from registers; there is no combinational path from inputs to them.

Test Plan:
- Reset with req_i=2'b11 held → gnt_o=0 and cam_valid_o=0 during reset. First cycle after reset, gnt_o=2'b01; next eligible cycle with both requesting, gnt_o=2'b10.
- Req0 writes key 0x0012 / val 0xBEEF in cycle t; req1 reads 0x0012 at t+1 → cam_rw_n_o=0 at t, 1 at t+1. resp_valid_o[1] at t+3 with hit=1, val=0xBEEF. resp_valid_o[0] at t+2 with hit=0.
- Req1 reads unwritten key 0x7777 → resp_hit_o[1]=0, resp_val_o[1]=0 two cycles after grant.
- Req0 with resp_ready_i[0]=0 for 5 cycles after its response → resp_valid_o[0] and data held stable; gnt_o[0] stays 0 despite req_i[0]=1; req1 keeps getting grants. One cycle after resp_ready_i[0]=1, gnt_o[0] asserts.
- Both requesters continuously requesting with resp_ready=2'b11 for 20 cycles → grants alternate, each requester granted every ≤3 cycles, grant counts differ by ≤1.
- Assert rst the cycle after a read grant → no resp_valid_o afterwards; post-reset state matches the first scenario.
